// File: rtl/uart_dma_pkg.sv
// Shared types and helpers for the UART frame DMA: state encodings, the
// length-field width and the pointer-width helper.
package uart_dma_pkg;

    localparam int LEN_W = 9;
    localparam logic [7:0] DEF_HDR_BYTE = 8'h55;

    typedef enum logic [1:0] {P_IDLE, P_HDR, P_PAY, P_CHK} parse_state_t;
    typedef enum logic       {R_IDLE, R_STREAM}            rd_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP}       tx_state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Byte FIFO with a separate commit pointer: readers only see committed data,
// and a rollback discards everything written since the last commit.
module frame_fifo
    import uart_dma_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         rollback,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = ptr_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  cmt_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // A commit in the same cycle as a write includes that write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rollback)   wr_ptr <= cmt_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (commit && !rollback) cmt_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (cmt_ptr == rd_ptr);

endmodule

// File: rtl/uart_frame_dma.sv
// UART frame DMA: parses framed RX bytes into a commit/rollback FIFO, replays
// good frames as a stream with length/last, and paces an outbound TX stream.
module uart_frame_dma
    import uart_dma_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
    parameter int         HDR_LEN     = 3,
    parameter int         LEN_IDX     = 2,
    parameter int         CHK_EN      = 1,
    parameter int         RX_DEPTH    = 1024,
    parameter int         MAX_FRAMES  = 4,
    parameter int         TX_DEPTH    = 1024,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         TX_GAP      = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_user_rx_data,
    input  logic             i_user_rx_valid,
    output logic [7:0]       o_user_tx_data,
    output logic             o_user_tx_valid,
    input  logic             i_user_tx_ready,
    input  logic [7:0]       i_uart_send_data,
    input  logic             i_uart_send_last,
    input  logic             i_uart_send_valid,
    output logic             o_uart_send_ready,
    output logic [7:0]       o_uart_rec_data,
    output logic             o_uart_rec_valid,
    input  logic             i_uart_rec_ready,
    output logic             o_uart_rec_last,
    output logic [LEN_W-1:0] o_uart_rec_len,
    output logic             o_err_pulse,
    output logic [7:0]       o_err_cnt,
    output logic [4:0]       o_dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid && ready;
    // a source holds data (and last/len) stable while valid && !ready.

    localparam int LFW = ptr_w(MAX_FRAMES);

    logic [7:0] rxd;
    logic       rxv;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rxd <= '0;
            rxv <= 1'b0;
        end else begin
            rxd <= i_user_rx_data;
            rxv <= i_user_rx_valid;
        end
    end

    parse_state_t     p_state, p_next;
    logic [LEN_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       len_q, len_nxt, len_val, xor_q, xor_nxt;
    logic [31:0]      tmr_q;
    logic             d_wr, d_full, d_empty, d_rd, want_commit, chk_bad, abort;
    logic             commit, rollback, pay_end, tmo_hit;
    logic [7:0]       d_rd_data;

    logic [LEN_W-1:0] lf_mem [MAX_FRAMES];
    logic [LFW:0]     lf_wp, lf_rp;
    logic             lf_full, lf_empty, lf_pop;

    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmr_q == 32'(TIMEOUT_CYC - 1));
    assign pay_end = (cnt_q == LEN_W'(HDR_LEN - 1) + LEN_W'(len_q));
    assign len_val = (cnt_q == LEN_W'(LEN_IDX)) ? rxd : len_q;

    always_comb begin
        p_next      = p_state;
        d_wr        = 1'b0;
        want_commit = 1'b0;
        chk_bad     = 1'b0;
        abort       = 1'b0;
        cnt_nxt     = cnt_q + 1'b1;
        len_nxt     = len_q;
        xor_nxt     = xor_q ^ rxd;
        if (rxv) begin
            case (p_state)
                P_IDLE: if (rxd == HDR_BYTE) begin
                    d_wr    = 1'b1;
                    cnt_nxt = LEN_W'(1);
                    xor_nxt = rxd;
                    p_next  = P_HDR;
                end
                P_HDR: begin
                    d_wr    = 1'b1;
                    len_nxt = len_val;
                    if (cnt_q == LEN_W'(HDR_LEN - 1)) begin
                        if (len_val != 8'd0) p_next = P_PAY;
                        else if (CHK_EN != 0) p_next = P_CHK;
                        else begin
                            want_commit = 1'b1;
                            p_next      = P_IDLE;
                        end
                    end
                end
                P_PAY: begin
                    d_wr = 1'b1;
                    if (pay_end) begin
                        if (CHK_EN != 0) p_next = P_CHK;
                        else begin
                            want_commit = 1'b1;
                            p_next      = P_IDLE;
                        end
                    end
                end
                P_CHK: begin
                    d_wr   = 1'b1;
                    p_next = P_IDLE;
                    if (rxd == xor_q) want_commit = 1'b1;
                    else              chk_bad     = 1'b1;
                end
                default: p_next = P_IDLE;
            endcase
            if (d_wr && d_full) begin
                d_wr        = 1'b0;
                want_commit = 1'b0;
                chk_bad     = 1'b0;
                abort       = 1'b1;
                p_next      = P_IDLE;
            end
        end else if (p_state != P_IDLE && tmo_hit) begin
            abort  = 1'b1;
            p_next = P_IDLE;
        end
        commit   = want_commit && !lf_full;
        rollback = abort || chk_bad || (want_commit && lf_full);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p_state <= P_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            xor_q   <= '0;
            tmr_q   <= '0;
        end else begin
            p_state <= p_next;
            if (d_wr) begin
                cnt_q <= cnt_nxt;
                len_q <= len_nxt;
                xor_q <= xor_nxt;
            end
            if (p_state == P_IDLE || rxv) tmr_q <= '0;
            else                          tmr_q <= tmr_q + 1'b1;
        end
    end

    frame_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk(i_clk), .rst(i_rst), .wr_en(d_wr), .wr_data(rxd),
        .commit(commit), .rollback(rollback), .rd_en(d_rd),
        .rd_data(d_rd_data), .full(d_full), .empty(d_empty)
    );

    // A length entry stays queued until its frame's last byte is handed off,
    // so the frame being streamed still counts toward MAX_FRAMES.
    always_ff @(posedge i_clk) begin
        if (commit) lf_mem[lf_wp[LFW-1:0]] <= cnt_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lf_wp <= '0;
            lf_rp <= '0;
        end else begin
            if (commit) lf_wp <= lf_wp + 1'b1;
            if (lf_pop) lf_rp <= lf_rp + 1'b1;
        end
    end

    assign lf_full  = (lf_wp[LFW] != lf_rp[LFW]) && (lf_wp[LFW-1:0] == lf_rp[LFW-1:0]);
    assign lf_empty = (lf_wp == lf_rp);

    rd_state_t        r_state, r_next;
    logic [LEN_W-1:0] rec_len_q, rd_cnt;
    logic             load_len, rec_valid, rec_last;

    assign rec_last = (r_state == R_STREAM) && (rd_cnt == rec_len_q - 1'b1);

    always_comb begin
        r_next    = r_state;
        d_rd      = 1'b0;
        lf_pop    = 1'b0;
        load_len  = 1'b0;
        rec_valid = 1'b0;
        case (r_state)
            R_IDLE: if (!lf_empty) begin
                load_len = 1'b1;
                r_next   = R_STREAM;
            end
            R_STREAM: begin
                rec_valid = !d_empty;
                if (rec_valid && i_uart_rec_ready) begin
                    d_rd = 1'b1;
                    if (rec_last) begin
                        lf_pop = 1'b1;
                        r_next = R_IDLE;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= R_IDLE;
            rec_len_q   <= '0;
            rd_cnt      <= '0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            r_state <= r_next;
            if (load_len) begin
                rec_len_q <= lf_mem[lf_rp[LFW-1:0]];
                rd_cnt    <= '0;
            end else if (d_rd) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            o_err_pulse <= rollback;
            if (rollback && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    assign o_uart_rec_valid = rec_valid;
    assign o_uart_rec_data  = rec_valid ? d_rd_data : 8'd0;
    assign o_uart_rec_last  = rec_valid && rec_last;
    assign o_uart_rec_len   = rec_len_q;

    tx_state_t   t_state, t_next;
    logic        rdy_en, t_wr, t_rd, t_full, t_empty;
    logic [7:0]  t_rd_data, tx_data_q;
    logic [15:0] gap_q;
    logic        unused_send_last;

    assign unused_send_last  = i_uart_send_last;
    assign o_uart_send_ready = rdy_en && !t_full;
    assign t_wr              = i_uart_send_valid && o_uart_send_ready;

    frame_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk(i_clk), .rst(i_rst), .wr_en(t_wr), .wr_data(i_uart_send_data),
        .commit(t_wr), .rollback(1'b0), .rd_en(t_rd),
        .rd_data(t_rd_data), .full(t_full), .empty(t_empty)
    );

    always_comb begin
        t_next = t_state;
        t_rd   = 1'b0;
        case (t_state)
            T_IDLE: if (!t_empty) begin
                t_rd   = 1'b1;
                t_next = T_SEND;
            end
            T_SEND: if (i_user_tx_ready) t_next = (TX_GAP > 0) ? T_GAP : T_IDLE;
            T_GAP:  if (gap_q == 16'(TX_GAP - 1)) t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            t_state   <= T_IDLE;
            tx_data_q <= '0;
            gap_q     <= '0;
            rdy_en    <= 1'b0;
        end else begin
            t_state <= t_next;
            rdy_en  <= 1'b1;
            if (t_rd) tx_data_q <= t_rd_data;
            if (t_state != T_GAP) gap_q <= '0;
            else                  gap_q <= gap_q + 1'b1;
        end
    end

    assign o_user_tx_data  = tx_data_q;
    assign o_user_tx_valid = (t_state == T_SEND);
    assign o_dbg_state     = {p_state, r_state, t_state};

endmodule

// File: tb/tb_uart_frame_dma.sv
// Bench for uart_frame_dma: frames are built from the framing rules, good ones
// are queued as expected stream bytes, and the DUT stream is compared against them.
module tb_uart_frame_dma;

    localparam int HDR_LEN = 3;
    localparam int CHK_EN  = 1;
    localparam int TMO     = 16;
    localparam int GAP     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] send_data = '0;
    logic       send_last = 1'b0;
    logic       send_valid = 1'b0;
    logic       send_ready;
    logic [7:0] rec_data;
    logic       rec_valid;
    logic       rec_ready = 1'b0;
    logic       rec_last;
    logic [8:0] rec_len;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [4:0] dbg_state;

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    uart_frame_dma #(
        .HDR_BYTE(8'h55), .HDR_LEN(HDR_LEN), .LEN_IDX(2), .CHK_EN(CHK_EN),
        .RX_DEPTH(1024), .MAX_FRAMES(4), .TX_DEPTH(1024),
        .TIMEOUT_CYC(TMO), .TX_GAP(GAP)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_user_rx_data(rx_data), .i_user_rx_valid(rx_valid),
        .o_user_tx_data(tx_data), .o_user_tx_valid(tx_valid), .i_user_tx_ready(tx_ready),
        .i_uart_send_data(send_data), .i_uart_send_last(send_last),
        .i_uart_send_valid(send_valid), .o_uart_send_ready(send_ready),
        .o_uart_rec_data(rec_data), .o_uart_rec_valid(rec_valid),
        .i_uart_rec_ready(rec_ready), .o_uart_rec_last(rec_last), .o_uart_rec_len(rec_len),
        .o_err_pulse(err_pulse), .o_err_cnt(err_cnt), .o_dbg_state(dbg_state)
    );

    // scoreboard state
    logic [7:0] exp_q[$];
    logic       exp_last_q[$];
    logic [8:0] exp_len_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [8:0] got_len_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] tx_got_q[$];
    logic [7:0] frm[$];
    int exp_err = 0;
    int pulse_cnt = 0;
    int stable_viol = 0;
    int tx_viol = 0;
    int gap_viol = 0;
    int n_vec = 0;
    int n_err = 0;
    int rmode = 1;
    int tmode = 1;

    // ready drivers: 0 = low, 1 = high, 2 = random
    always @(posedge clk) begin
        #1;
        rec_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        tx_ready  = (tmode == 2) ? 1'($urandom_range(0, 1)) : (tmode == 1);
    end

    // monitor: records handshakes and protocol-rule violations
    logic       rs_stall = 1'b0, tx_stall = 1'b0, rs_plast = 1'b0;
    logic [7:0] rs_pdata = '0, tx_pdata = '0;
    logic [8:0] rs_plen = '0;
    int         last_hs = -100;
    always @(negedge clk) begin
        if (rst) begin
            rs_stall = 1'b0;
            tx_stall = 1'b0;
            last_hs  = -100;
        end else begin
            if (rs_stall && !(rec_valid && rec_data == rs_pdata && rec_last == rs_plast && rec_len == rs_plen))
                stable_viol++;
            if (rec_valid && rec_ready) begin
                got_q.push_back(rec_data);
                got_last_q.push_back(rec_last);
                got_len_q.push_back(rec_len);
            end
            rs_stall = rec_valid && !rec_ready;
            rs_pdata = rec_data;
            rs_plast = rec_last;
            rs_plen  = rec_len;
            if (err_pulse) pulse_cnt++;
            if (tx_stall && !(tx_valid && tx_data == tx_pdata)) tx_viol++;
            if (tx_valid && tx_ready) begin
                tx_got_q.push_back(tx_data);
                if (cyc - last_hs < GAP + 1) gap_viol++;
                last_hs = cyc;
            end
            tx_stall = tx_valid && !tx_ready;
            tx_pdata = tx_data;
        end
    end

    // driver tasks and reference model
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input int len);
        logic [7:0] x;
        frm.delete();
        frm.push_back(8'h55);
        frm.push_back(8'($urandom_range(0, 255)));
        frm.push_back(8'(len));
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (frm[i]) x ^= frm[i];
        frm.push_back(x);
    endtask

    task automatic expect_frame();
        foreach (frm[i]) begin
            exp_q.push_back(frm[i]);
            exp_last_q.push_back(i == frm.size() - 1);
            exp_len_q.push_back(9'(frm.size()));
        end
    endtask

    task automatic drive_frame();
        foreach (frm[i]) begin
            @(posedge clk); #1;
            rx_data  = frm[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic wait_rx(input int n, output bit to);
        int b;
        b  = 0;
        to = 1'b0;
        while (got_q.size() < n) begin
            @(negedge clk);
            b++;
            if (b > 5000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        int w;
        send_data  = b;
        send_last  = 1'($urandom_range(0, 1));
        send_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!send_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (!send_ready) begin
            n_err++;
            $display("FAIL send_ready_wait: ready=%0b required 1", send_ready);
        end
        @(posedge clk); #1;
        send_valid = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        tick(3);
        @(negedge clk);
        n_vec++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL rst_rec_valid: got %0b required 0", rec_valid); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %0b required 0", tx_valid); end
        n_vec++; if (send_ready !== 1'b0) begin n_err++; $display("FAIL rst_send_ready: got %0b required 0", send_ready); end
        n_vec++; if (err_cnt !== 8'd0 || err_pulse !== 1'b0) begin n_err++; $display("FAIL rst_err: cnt=%0d pulse=%0b required 0/0", err_cnt, err_pulse); end
        n_vec++; if (rec_len !== 9'd0 || tx_data !== 8'd0 || rec_data !== 8'd0) begin n_err++; $display("FAIL rst_data: len=%0d tx=%h rec=%h required 0", rec_len, tx_data, rec_data); end
        n_vec++; if (dbg_state !== 5'd0) begin n_err++; $display("FAIL rst_state: got %h required 0", dbg_state); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (send_ready !== 1'b0) begin n_err++; $display("FAIL rel_send_ready_early: got %0b required 0", send_ready); end
        @(negedge clk);
        n_vec++; if (send_ready !== 1'b1) begin n_err++; $display("FAIL rel_send_ready: got %0b required 1", send_ready); end
    endtask

    task automatic test_good_frame();
        bit to;
        logic [7:0] fixed [7] = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'hFC};
        frm.delete();
        foreach (fixed[i]) frm.push_back(fixed[i]);
        expect_frame();
        drive_frame();
        wait_rx(exp_q.size(), to);
        n_vec++; if (to) begin n_err++; $display("FAIL good_wait: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_vec++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_len_q[0] !== exp_len_q[0]) begin
                n_err++;
                $display("FAIL good_byte: got %h/%0b/%0d required %h/%0b/%0d", got_q[0], got_last_q[0], got_len_q[0], exp_q[0], exp_last_q[0], exp_len_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_len_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_len_q.pop_front());
        end
        exp_q.delete(); exp_last_q.delete(); exp_len_q.delete();
        n_vec++; if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL good_err_cnt: got %0d required %0d", err_cnt, exp_err); end
    endtask

    task automatic test_bad_chk();
        bit to;
        int p0;
        p0 = pulse_cnt;
        build_frame(3);
        frm[frm.size() - 1] ^= 8'h5A;
        exp_err++;
        drive_frame();
        tick(8);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL bad_no_output: got %0d bytes required 0", got_q.size()); end
        n_vec++; if (pulse_cnt - p0 != 1) begin n_err++; $display("FAIL bad_pulse: got %0d pulses required 1", pulse_cnt - p0); end
        n_vec++; if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL bad_err_cnt: got %0d required %0d", err_cnt, exp_err); end
        build_frame($urandom_range(1, 8));
        expect_frame();
        drive_frame();
        wait_rx(exp_q.size(), to);
        n_vec++; if (to) begin n_err++; $display("FAIL after_bad_wait: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_vec++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_len_q[0] !== exp_len_q[0]) begin
                n_err++;
                $display("FAIL after_bad_byte: got %h/%0b/%0d required %h/%0b/%0d", got_q[0], got_last_q[0], got_len_q[0], exp_q[0], exp_last_q[0], exp_len_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_len_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_len_q.pop_front());
        end
        exp_q.delete(); exp_last_q.delete(); exp_len_q.delete();
    endtask

    task automatic test_queue_full();
        bit to;
        int lasts;
        rmode = 0;
        tick(2);
        for (int f = 0; f < 5; f++) begin
            build_frame(1);
            if (f < 4) expect_frame();
            else       exp_err++;
            drive_frame();
        end
        tick(10);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL qfull_stalled: got %0d bytes required 0", got_q.size()); end
        n_vec++; if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL qfull_err_cnt: got %0d required %0d", err_cnt, exp_err); end
        rmode = 1;
        wait_rx(exp_q.size(), to);
        tick(10);
        n_vec++; if (to || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL qfull_count: got %0d bytes required %0d", got_q.size(), exp_q.size()); end
        lasts = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_vec++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_len_q[0] !== exp_len_q[0]) begin
                n_err++;
                $display("FAIL qfull_byte: got %h/%0b/%0d required %h/%0b/%0d", got_q[0], got_last_q[0], got_len_q[0], exp_q[0], exp_last_q[0], exp_len_q[0]);
            end
            if (got_last_q[0]) lasts++;
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_len_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_len_q.pop_front());
        end
        exp_q.delete(); exp_last_q.delete(); exp_len_q.delete();
        got_q.delete(); got_last_q.delete(); got_len_q.delete();
        n_vec++; if (lasts != 4) begin n_err++; $display("FAIL qfull_lasts: got %0d required 4", lasts); end
    endtask

    task automatic test_timeout();
        int p0;
        p0 = pulse_cnt;
        build_frame(5);
        frm = frm[0:4];
        exp_err++;
        drive_frame();
        tick(TMO + 10);
        n_vec++; if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL tmo_err_cnt: got %0d required %0d", err_cnt, exp_err); end
        n_vec++; if (pulse_cnt - p0 != 1) begin n_err++; $display("FAIL tmo_pulse: got %0d pulses required 1", pulse_cnt - p0); end
        n_vec++; if (got_q.size() != 0 || rec_valid !== 1'b0) begin n_err++; $display("FAIL tmo_output: got %0d bytes valid=%0b required 0/0", got_q.size(), rec_valid); end
    endtask

    task automatic test_long_frame();
        bit to;
        int nb;
        rmode = 2;
        build_frame(255);
        expect_frame();
        nb = exp_q.size();
        drive_frame();
        wait_rx(nb, to);
        tick(10);
        rmode = 1;
        n_vec++; if (to || got_q.size() != 259) begin n_err++; $display("FAIL long_count: got %0d bytes required 259", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_vec++;
            if (got_q[0] !== exp_q[0] || got_last_q[0] !== exp_last_q[0] || got_len_q[0] !== exp_len_q[0]) begin
                n_err++;
                $display("FAIL long_byte: got %h/%0b/%0d required %h/%0b/%0d", got_q[0], got_last_q[0], got_len_q[0], exp_q[0], exp_last_q[0], exp_len_q[0]);
            end
            void'(got_q.pop_front()); void'(got_last_q.pop_front()); void'(got_len_q.pop_front());
            void'(exp_q.pop_front()); void'(exp_last_q.pop_front()); void'(exp_len_q.pop_front());
        end
        exp_q.delete(); exp_last_q.delete(); exp_len_q.delete();
        got_q.delete(); got_last_q.delete(); got_len_q.delete();
        n_vec++; if (stable_viol != 0) begin n_err++; $display("FAIL rec_stable: got %0d violations required 0", stable_viol); end
        n_vec++; if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL long_err_cnt: got %0d required %0d", err_cnt, exp_err); end
    endtask

    task automatic test_tx();
        int b;
        tmode = 2;
        for (int i = 0; i < 8; i++) begin
            tx_exp_q.push_back(8'(i));
            send_tx(8'(i));
        end
        b = 0;
        while (tx_got_q.size() < 8 && b < 2000) begin
            @(negedge clk);
            b++;
        end
        n_vec++; if (tx_got_q.size() != 8) begin n_err++; $display("FAIL tx_count: got %0d bytes required 8", tx_got_q.size()); end
        while (tx_exp_q.size() > 0 && tx_got_q.size() > 0) begin
            n_vec++;
            if (tx_got_q[0] !== tx_exp_q[0]) begin
                n_err++;
                $display("FAIL tx_byte: got %h required %h", tx_got_q[0], tx_exp_q[0]);
            end
            void'(tx_got_q.pop_front());
            void'(tx_exp_q.pop_front());
        end
        tx_exp_q.delete();
        n_vec++; if (gap_viol != 0) begin n_err++; $display("FAIL tx_gap: got %0d short gaps required 0", gap_viol); end
        n_vec++; if (tx_viol != 0) begin n_err++; $display("FAIL tx_stable: got %0d violations required 0", tx_viol); end
    endtask

    task automatic test_tx_reset();
        int b;
        tmode = 2;
        for (int i = 0; i < 6; i++) send_tx(8'h20 + 8'(i));
        tick(3);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        n_vec++; if (tx_valid !== 1'b0 || tx_data !== 8'd0) begin n_err++; $display("FAIL txrst_out: valid=%0b data=%h required 0/00", tx_valid, tx_data); end
        n_vec++; if (send_ready !== 1'b0 || rec_valid !== 1'b0) begin n_err++; $display("FAIL txrst_ready: send_ready=%0b rec_valid=%0b required 0/0", send_ready, rec_valid); end
        n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL txrst_err_cnt: got %0d required 0", err_cnt); end
        exp_err = 0;
        tx_got_q.delete();
        @(posedge clk); #1;
        rst   = 1'b0;
        tmode = 1;
        tick(40);
        n_vec++; if (tx_got_q.size() != 0) begin n_err++; $display("FAIL txrst_empty: got %0d bytes required 0", tx_got_q.size()); end
        send_tx(8'hA5);
        b = 0;
        while (tx_got_q.size() < 1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        n_vec++; if (tx_got_q.size() != 1 || tx_got_q[0] !== 8'hA5) begin n_err++; $display("FAIL txrst_after: got %0d bytes required 1 byte a5", tx_got_q.size()); end
        tx_got_q.delete();
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_queue_full();
        test_timeout();
        test_long_frame();
        test_tx();
        test_tx_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
